tl_rom_get_fragmenter: RTL and testbench
========================================

// Module: tl_rom_get_fragmenter
// PURPOSE
//  Sits directly upstream of the boot-ROM TileLink slave, inside the same clock-sink domain.
//  Accepts TL-UL/UH Get requests of up to 2^MAX_SIZE bytes from the periphery bus.
//  Splits each Get into 8-byte single-beat Gets, because the ROM slave only accepts size<=3.
//  Returns the ROM's D beats upstream, restoring the original size and source.
//  One outer transaction is in flight at a time.
// PARAMETERS
//  MAX_SIZE     6   log2 of the largest accepted Get in bytes (64B => 8 fragments)
//  SOURCE_W     12  A/D source-id width
//  ADDR_W       17  address width
//  BEAT_BYTES   8   data-bus bytes; the fragment size is log2(BEAT_BYTES)=3
// PORTS
//  clock             in   1        single clock
//  reset             in   1        synchronous, active-high
//  in_a_valid/ready  in/out 1      upstream A handshake
//  in_a_opcode       in   3        must be Get (4)
//  in_a_param        in   3        ignored, forwarded as 0
//  in_a_size         in   3        log2 bytes, 0..MAX_SIZE
//  in_a_source       in   SOURCE_W request id
//  in_a_address      in   ADDR_W   address, aligned to size
//  in_a_mask         in   8        byte mask (meaningful only when size<=3)
//  in_a_corrupt      in   1        forwarded on every fragment
//  in_d_valid/ready  out/in 1      upstream D handshake
//  in_d_size         out  3        original outer size
//  in_d_source       out  SOURCE_W original source
//  in_d_data         out  64       ROM data beat
//  out_a_valid/ready out/in 1      toward the ROM slave
//  out_a_opcode/param out 3/3      4 / 0
//  out_a_size        out  2        min(in size, 3)
//  out_a_source      out  SOURCE_W captured source
//  out_a_address     out  ADDR_W   fragment address
//  out_a_mask        out  8        fragment mask
//  out_a_corrupt     out  1        captured corrupt
//  out_d_valid/ready in/out 1      ROM D handshake
//  out_d_size/source/data in 2/SOURCE_W/64  ROM response
// BEHAVIOUR
//  - Reset: busy=0 and both counters=0.
//    Outputs after reset: in_a_ready=1, out_a_valid=0, in_d_valid=0, out_d_ready=0.
//  - Fragment count: N = (size<=3) ? 1 : 2^(size-3), held in a count register of width MAX_SIZE-3+1.
//  - Accept: in_a_ready = !busy.
//    On an in_a fire, capture source, size, address, mask and corrupt, and set busy.
//    a_cnt and d_cnt are cleared on the same fire.
//  - Issue: out_a_valid = busy && a_cnt<N, asserted from the cycle after the accept.
//    A single-fragment request reaches the ROM 1 cycle after acceptance.
//    out_a_address = base | (a_cnt<<3); the low 3 bits come from the captured address when N==1.
//    out_a_mask is all-ones when N>1, otherwise the captured mask.
//    out_a_size = min(size,3).
//    a_cnt increments on each out_a fire.
//  - Response path is combinational and adds no cycle:
//    in_d_valid = out_d_valid && busy
//    out_d_ready = in_d_ready && busy
//    in_d_data = out_d_data; in_d_size is the captured size; in_d_source is the captured source.
//  - d_cnt increments on each D fire. The D fire with d_cnt==N-1 clears busy.
//    in_a_ready returns to 1 in the next cycle; there is no back-to-back overlap.
//  - Issue and response may overlap; a fragment may issue while earlier D beats are pending.
//    If out_a and D fire in the same cycle, both counters update independently.
//  - A D beat while !busy is not consumed (out_d_ready=0); the ROM is never
//    allowed to respond unprompted, and a simulation assertion flags it.
//  - Upstream D stall: out_d_ready follows in_d_ready, so backpressure propagates to the ROM.
//  - The following violate the protocol; assertions flag them in simulation only:
//    a non-Get opcode, size>MAX_SIZE, a misaligned address.
//  - Reset mid-transaction: the synchronous reset abandons all state in one cycle.
//    The upstream source is reset by the same reset.
// STRUCTURE
//  - tl_rom_pkg holds:
//    TL_GET=3'd4, TL_ACCESS_ACK_DATA=3'd1, BEAT_LG=3
//    typedef tl_a_req_t for the captured A fields
//    function frag_count(size)
//  - A single sub-module, tl_frag_counter: a load/increment/terminal-count counter,
//    instantiated twice (a_cnt, d_cnt).
//  - Everything else is flat: one capture register and the combinational muxes.
// TESTING
//  - Get size=3, addr 0x10040, mask 0xFF -> one out_a (size 3, addr 0x10040), one in_d with size 3.
//  - Get size=6, addr 0x10000, source 0x2A5 ->
//    8 out_a at 0x10000..0x10038 with mask 0xFF, 8 in_d with size 6, source 0x2A5.
//    in_a_ready stays low until the 8th D fire.
//  - Get size=1, addr 0x10006, mask 0xC0 -> out_a size 1, addr 0x10006, mask 0xC0.
//  - Size=5 with in_d_ready toggling 1/0 and out_a_ready low on alternate cycles ->
//    4 beats in order, with no drop and no duplicate.
//  - Assert reset during the 3rd fragment of a size-6 Get ->
//    the next cycle shows in_a_ready=1 and out_a_valid=0.
//    A new size-3 Get then completes normally.

Source files
------------

// File: rtl/tl_rom_pkg.sv
// tl_rom_pkg: shared widths, TileLink opcodes and fragment helpers for the ROM Get fragmenter.
package tl_rom_pkg;
  localparam int MAX_SIZE = 6;
  localparam int SOURCE_W = 12;
  localparam int ADDR_W = 17;
  localparam int BEAT_BYTES = 8;
  localparam int BEAT_LG = $clog2(BEAT_BYTES);
  localparam int CNT_W = MAX_SIZE - BEAT_LG + 1;
  localparam logic [2:0] TL_GET = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;
  typedef struct packed {
    logic [SOURCE_W-1:0] source;
    logic [2:0]          size;
    logic [ADDR_W-1:0]   address;
    logic [7:0]          mask;
    logic                corrupt;
  } tl_a_req_t;
  function automatic logic [CNT_W-1:0] frag_count(input logic [2:0] size);
    return (size <= 3'(BEAT_LG)) ? CNT_W'(1) : CNT_W'(1) << (size - 3'(BEAT_LG));
  endfunction
endpackage

// File: rtl/tl_frag_counter.sv
// tl_frag_counter: clearable up-counter flagging when it has reached a terminal value.
module tl_frag_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
  assign tc = (cnt_q == limit);
endmodule

// File: rtl/tl_rom_get_fragmenter.sv
// tl_rom_get_fragmenter: splits one outer TileLink Get into 8-byte Gets for the boot ROM
// and returns the ROM beats upstream under the original size and source.
module tl_rom_get_fragmenter
  import tl_rom_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                in_a_valid,
  output logic                in_a_ready,
  input  logic [2:0]          in_a_opcode,
  input  logic [2:0]          in_a_param,
  input  logic [2:0]          in_a_size,
  input  logic [SOURCE_W-1:0] in_a_source,
  input  logic [ADDR_W-1:0]   in_a_address,
  input  logic [7:0]          in_a_mask,
  input  logic                in_a_corrupt,
  output logic                in_d_valid,
  input  logic                in_d_ready,
  output logic [2:0]          in_d_size,
  output logic [SOURCE_W-1:0] in_d_source,
  output logic [63:0]         in_d_data,
  output logic                out_a_valid,
  input  logic                out_a_ready,
  output logic [2:0]          out_a_opcode,
  output logic [2:0]          out_a_param,
  output logic [1:0]          out_a_size,
  output logic [SOURCE_W-1:0] out_a_source,
  output logic [ADDR_W-1:0]   out_a_address,
  output logic [7:0]          out_a_mask,
  output logic                out_a_corrupt,
  input  logic                out_d_valid,
  output logic                out_d_ready,
  input  logic [1:0]          out_d_size,
  input  logic [SOURCE_W-1:0] out_d_source,
  input  logic [63:0]         out_d_data
);
  tl_a_req_t req_q, req_d;
  logic busy_q, busy_d;
  logic [CNT_W-1:0] n, d_limit, a_cnt, d_cnt;
  logic a_in_fire, a_out_fire, d_fire, a_tc, d_tc;
  logic unused_param;
  assign unused_param = ^in_a_param;
  assign n = frag_count(req_q.size);
  assign d_limit = n - CNT_W'(1);
  always_comb begin
    in_a_ready = !busy_q;
    out_a_valid = busy_q && !a_tc;
    in_d_valid = out_d_valid && busy_q;
    out_d_ready = in_d_ready && busy_q;
    a_in_fire = in_a_valid && !busy_q;
    a_out_fire = out_a_valid && out_a_ready;
    d_fire = out_d_valid && out_d_ready;
    busy_d = a_in_fire ? 1'b1 : (d_fire && d_tc) ? 1'b0 : busy_q;
    req_d = a_in_fire ? tl_a_req_t'{source: in_a_source, size: in_a_size, address: in_a_address,
                                    mask: in_a_mask, corrupt: in_a_corrupt} : req_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= 1'b0;
      req_q <= '0;
    end else begin
      busy_q <= busy_d;
      req_q <= req_d;
    end
  end
  tl_frag_counter #(.W(CNT_W)) u_a_cnt (
    .clock(clock), .reset(reset), .clr(a_in_fire), .inc(a_out_fire),
    .limit(n), .cnt(a_cnt), .tc(a_tc)
  );
  tl_frag_counter #(.W(CNT_W)) u_d_cnt (
    .clock(clock), .reset(reset), .clr(a_in_fire), .inc(d_fire),
    .limit(d_limit), .cnt(d_cnt), .tc(d_tc)
  );
  // Single-fragment Gets keep their sub-beat offset; larger ones are beat aligned.
  always_comb begin
    out_a_opcode = TL_GET;
    out_a_param = 3'd0;
    out_a_size = (req_q.size > 3'(BEAT_LG)) ? 2'(BEAT_LG) : req_q.size[1:0];
    out_a_source = req_q.source;
    out_a_address = (n == CNT_W'(1)) ? req_q.address : req_q.address | ADDR_W'({a_cnt, BEAT_LG'(0)});
    out_a_mask = (n == CNT_W'(1)) ? req_q.mask : 8'hFF;
    out_a_corrupt = req_q.corrupt;
    in_d_size = req_q.size;
    in_d_source = req_q.source;
    in_d_data = out_d_data;
  end
  a_get_only: assert property (@(posedge clock) disable iff (reset) in_a_valid |-> in_a_opcode == TL_GET);
  a_size_ok: assert property (@(posedge clock) disable iff (reset) in_a_valid |-> in_a_size <= 3'(MAX_SIZE));
  a_aligned: assert property (@(posedge clock) disable iff (reset)
    in_a_valid |-> (in_a_address & ~({ADDR_W{1'b1}} << in_a_size)) == '0);
  d_prompted: assert property (@(posedge clock) disable iff (reset) !busy_q |-> !out_d_valid);
  d_in_range: assert property (@(posedge clock) disable iff (reset) d_fire |-> d_cnt < n);
  d_matches: assert property (@(posedge clock) disable iff (reset)
    d_fire |-> (out_d_source == req_q.source && out_d_size == out_a_size));
endmodule

// File: tb/tb_tl_rom_get_fragmenter.sv
// tb_tl_rom_get_fragmenter: directed bench with a queued ROM responder model.
module tb_tl_rom_get_fragmenter;
  import tl_rom_pkg::*;
  logic clock, reset;
  logic in_a_valid, in_a_ready, in_a_corrupt, in_d_valid, in_d_ready;
  logic [2:0] in_a_opcode, in_a_param, in_a_size, in_d_size;
  logic [SOURCE_W-1:0] in_a_source, in_d_source, out_a_source, out_d_source;
  logic [ADDR_W-1:0] in_a_address, out_a_address;
  logic [7:0] in_a_mask, out_a_mask;
  logic [63:0] in_d_data, out_d_data;
  logic out_a_valid, out_a_ready, out_a_corrupt, out_d_valid, out_d_ready;
  logic [2:0] out_a_opcode, out_a_param;
  logic [1:0] out_a_size, out_d_size;

  tl_rom_get_fragmenter dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
    .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
    .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_corrupt(in_a_corrupt),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_size(in_d_size),
    .in_d_source(in_d_source), .in_d_data(in_d_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_corrupt(out_a_corrupt),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_size(out_d_size),
    .out_d_source(out_d_source), .out_d_data(out_d_data)
  );

  typedef struct {
    logic [ADDR_W-1:0]   addr;
    logic [1:0]          size;
    logic [SOURCE_W-1:0] src;
    logic [7:0]          mask;
    logic                corrupt;
    logic [2:0]          op;
    logic [2:0]          param;
  } frag_t;
  typedef struct {
    logic [63:0]         data;
    logic [2:0]          size;
    logic [SOURCE_W-1:0] src;
  } beat_t;

  frag_t frags[$];
  frag_t rom_q[$];
  beat_t beats[$];
  int compared = 0, mismatched = 0;
  int cyc = 0, acc_cyc = 0, first_frag_cyc = 0, exp_beats = 0, early = 0;
  bit accepted = 0, tb_busy = 0, stall = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [63:0] rom_word(input logic [ADDR_W-1:0] a);
    return {15'h0000, a, 15'h7FFF, a};
  endfunction

  // One bench cycle: drive ROM/backpressure at the falling edge, sample, log fires.
  task automatic cycle();
    frag_t f;
    beat_t b;
    out_d_valid = rom_q.size() > 0;
    if (rom_q.size() > 0) begin
      out_d_data = rom_word(rom_q[0].addr);
      out_d_size = rom_q[0].size;
      out_d_source = rom_q[0].src;
    end
    if (stall) begin
      in_d_ready = (cyc % 2 == 1);
      out_a_ready = (cyc % 2 == 0);
    end
    #1;
    if (tb_busy && in_a_ready) early++;
    if (in_a_valid && in_a_ready) begin
      accepted = 1;
      acc_cyc = cyc;
      tb_busy = 1;
    end
    if (out_a_valid && out_a_ready) begin
      f = '{addr: out_a_address, size: out_a_size, src: out_a_source, mask: out_a_mask,
            corrupt: out_a_corrupt, op: out_a_opcode, param: out_a_param};
      frags.push_back(f);
      rom_q.push_back(f);
      if (frags.size() == 1) first_frag_cyc = cyc;
    end
    if (in_d_valid && in_d_ready) begin
      b = '{data: in_d_data, size: in_d_size, src: in_d_source};
      beats.push_back(b);
      if (rom_q.size() > 0) void'(rom_q.pop_front());
      if (beats.size() == exp_beats) tb_busy = 0;
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic start(input logic [2:0] size, input logic [ADDR_W-1:0] addr,
                       input logic [SOURCE_W-1:0] src, input logic [7:0] mask,
                       input logic corr, input int nbeats);
    frags.delete();
    beats.delete();
    exp_beats = nbeats;
    accepted = 0;
    early = 0;
    in_a_valid = 1;
    in_a_opcode = TL_GET;
    in_a_param = 3'd5;
    in_a_size = size;
    in_a_source = src;
    in_a_address = addr;
    in_a_mask = mask;
    in_a_corrupt = corr;
    for (int i = 0; i < 20 && !accepted; i++) cycle();
    in_a_valid = 0;
  endtask

  task automatic send(input logic [2:0] size, input logic [ADDR_W-1:0] addr,
                      input logic [SOURCE_W-1:0] src, input logic [7:0] mask,
                      input logic corr, input int nbeats);
    start(size, addr, src, mask, corr, nbeats);
    for (int i = 0; i < 300 && beats.size() < nbeats; i++) cycle();
  endtask

  task automatic check_counts(input string name, input int nf, input int nb);
    compared++;
    if (frags.size() !== nf) begin
      mismatched++;
      $display("FAIL %s frag count: got %0d expected %0d", name, frags.size(), nf);
    end
    compared++;
    if (beats.size() !== nb) begin
      mismatched++;
      $display("FAIL %s beat count: got %0d expected %0d", name, beats.size(), nb);
    end
  endtask

  task automatic check_ready_after(input string name);
    #1;
    compared++;
    if (in_a_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s in_a_ready after done: got %b expected 1", name, in_a_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    out_d_valid = 1;
    in_d_ready = 1;
    out_a_ready = 1;
    repeat (3) @(negedge clock);
    #1;
    compared++;
    if (in_a_ready !== 1'b1) begin mismatched++; $display("FAIL reset in_a_ready: got %b expected 1", in_a_ready); end
    compared++;
    if (out_a_valid !== 1'b0) begin mismatched++; $display("FAIL reset out_a_valid: got %b expected 0", out_a_valid); end
    compared++;
    if (in_d_valid !== 1'b0) begin mismatched++; $display("FAIL reset in_d_valid: got %b expected 0", in_d_valid); end
    compared++;
    if (out_d_ready !== 1'b0) begin mismatched++; $display("FAIL reset out_d_ready: got %b expected 0", out_d_ready); end
    out_d_valid = 0;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_single();
    send(3'd3, 17'h10040, 12'h011, 8'hFF, 1'b0, 1);
    check_counts("single", 1, 1);
    if (frags.size() == 1 && beats.size() == 1) begin
      compared++;
      if (frags[0].addr !== 17'h10040 || frags[0].size !== 2'd3 || frags[0].mask !== 8'hFF) begin
        mismatched++;
        $display("FAIL single frag: got addr %h size %0d mask %h expected 10040 3 ff",
                 frags[0].addr, frags[0].size, frags[0].mask);
      end
      compared++;
      if (frags[0].op !== 3'd4 || frags[0].param !== 3'd0 || frags[0].src !== 12'h011) begin
        mismatched++;
        $display("FAIL single op/param/src: got %0d %0d %h expected 4 0 011",
                 frags[0].op, frags[0].param, frags[0].src);
      end
      compared++;
      if (beats[0].size !== 3'd3 || beats[0].src !== 12'h011 || beats[0].data !== rom_word(17'h10040)) begin
        mismatched++;
        $display("FAIL single beat: got size %0d src %h data %h expected 3 011 %h",
                 beats[0].size, beats[0].src, beats[0].data, rom_word(17'h10040));
      end
      compared++;
      if (first_frag_cyc - acc_cyc !== 1) begin
        mismatched++;
        $display("FAIL single latency: got %0d expected 1", first_frag_cyc - acc_cyc);
      end
    end
    check_ready_after("single");
  endtask

  task automatic test_burst();
    logic [ADDR_W-1:0] ea;
    send(3'd6, 17'h10000, 12'h2A5, 8'h0F, 1'b1, 8);
    check_counts("burst", 8, 8);
    for (int i = 0; i < 8 && i < frags.size() && i < beats.size(); i++) begin
      ea = 17'h10000 + 17'(i * 8);
      compared++;
      if (frags[i].addr !== ea || frags[i].mask !== 8'hFF || frags[i].size !== 2'd3 ||
          frags[i].corrupt !== 1'b1 || frags[i].src !== 12'h2A5) begin
        mismatched++;
        $display("FAIL burst frag %0d: got addr %h mask %h size %0d corrupt %b src %h expected %h ff 3 1 2a5",
                 i, frags[i].addr, frags[i].mask, frags[i].size, frags[i].corrupt, frags[i].src, ea);
      end
      compared++;
      if (beats[i].size !== 3'd6 || beats[i].src !== 12'h2A5 || beats[i].data !== rom_word(ea)) begin
        mismatched++;
        $display("FAIL burst beat %0d: got size %0d src %h data %h expected 6 2a5 %h",
                 i, beats[i].size, beats[i].src, beats[i].data, rom_word(ea));
      end
    end
    compared++;
    if (early !== 0) begin
      mismatched++;
      $display("FAIL burst in_a_ready early: got %0d cycles expected 0", early);
    end
    check_ready_after("burst");
  endtask

  task automatic test_subbeat();
    send(3'd1, 17'h10006, 12'h7FF, 8'hC0, 1'b0, 1);
    check_counts("subbeat", 1, 1);
    if (frags.size() == 1 && beats.size() == 1) begin
      compared++;
      if (frags[0].addr !== 17'h10006 || frags[0].size !== 2'd1 || frags[0].mask !== 8'hC0) begin
        mismatched++;
        $display("FAIL subbeat frag: got addr %h size %0d mask %h expected 10006 1 c0",
                 frags[0].addr, frags[0].size, frags[0].mask);
      end
      compared++;
      if (beats[0].size !== 3'd1 || beats[0].src !== 12'h7FF) begin
        mismatched++;
        $display("FAIL subbeat beat: got size %0d src %h expected 1 7ff", beats[0].size, beats[0].src);
      end
    end
    check_ready_after("subbeat");
  endtask

  task automatic test_stall();
    logic [ADDR_W-1:0] ea;
    stall = 1;
    send(3'd5, 17'h10020, 12'h123, 8'hFF, 1'b0, 4);
    stall = 0;
    in_d_ready = 1;
    out_a_ready = 1;
    repeat (5) cycle();
    check_counts("stall", 4, 4);
    for (int i = 0; i < 4 && i < frags.size() && i < beats.size(); i++) begin
      ea = 17'h10020 + 17'(i * 8);
      compared++;
      if (frags[i].addr !== ea || beats[i].data !== rom_word(ea) || beats[i].size !== 3'd5) begin
        mismatched++;
        $display("FAIL stall %0d: got addr %h data %h size %0d expected %h %h 5",
                 i, frags[i].addr, beats[i].data, beats[i].size, ea, rom_word(ea));
      end
    end
  endtask

  task automatic test_reset_mid();
    in_d_ready = 0;
    out_a_ready = 1;
    start(3'd6, 17'h10080, 12'h0AB, 8'hFF, 1'b0, 8);
    for (int i = 0; i < 20 && frags.size() < 2; i++) cycle();
    #1;
    compared++;
    if (out_a_valid !== 1'b1 || out_a_address !== 17'h10090) begin
      mismatched++;
      $display("FAIL midreset third frag: got valid %b addr %h expected 1 10090", out_a_valid, out_a_address);
    end
    reset = 1;
    rom_q.delete();
    out_d_valid = 0;
    out_a_ready = 0;
    @(negedge clock);
    #1;
    compared++;
    if (in_a_ready !== 1'b1 || out_a_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset state: got in_a_ready %b out_a_valid %b expected 1 0", in_a_ready, out_a_valid);
    end
    reset = 0;
    tb_busy = 0;
    in_d_ready = 1;
    out_a_ready = 1;
    @(negedge clock);
    send(3'd3, 17'h10100, 12'h005, 8'hFF, 1'b0, 1);
    check_counts("after reset", 1, 1);
    if (frags.size() == 1 && beats.size() == 1) begin
      compared++;
      if (frags[0].addr !== 17'h10100 || beats[0].data !== rom_word(17'h10100) || beats[0].src !== 12'h005) begin
        mismatched++;
        $display("FAIL after reset: got addr %h data %h src %h expected 10100 %h 005",
                 frags[0].addr, beats[0].data, beats[0].src, rom_word(17'h10100));
      end
    end
    check_ready_after("after reset");
  endtask

  initial begin
    in_a_valid = 0;
    in_a_opcode = TL_GET;
    in_a_param = 0;
    in_a_size = 0;
    in_a_source = 0;
    in_a_address = 0;
    in_a_mask = 0;
    in_a_corrupt = 0;
    out_d_data = 0;
    out_d_size = 0;
    out_d_source = 0;
    test_reset();
    test_single();
    test_burst();
    test_subbeat();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
